// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: trigger-and-capture trace unit for the 16-bit pipelined CPU.
// It records NUM_CH stage buses into a circular buffer on each qualified cycle.
// Capture stops a programmable number of samples after a masked-compare trigger.
// The capture is then drained oldest-first over a valid/ready port.
// Optional feature macro: PIPE_TRACE_TIMESTAMP_EN. When it is defined, a 16-bit
// cycle stamp is stored with every sample and presented on rd_ts.
module pipe_trace_buffer #(
   parameter int DATA_W = 16,
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH),
   parameter int SW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     sample_en,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic                     arm,
   input  logic                     abort,
   input  logic [SW-1:0]            trig_ch,
   input  logic [DATA_W-1:0]        trig_value,
   input  logic [DATA_W-1:0]        trig_mask,
   input  logic [AW-1:0]            post_count,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [NUM_CH*DATA_W-1:0] rd_data,
   output logic                     rd_last,
   output logic [1:0]               state,
   output logic [AW:0]              fill
`ifdef PIPE_TRACE_TIMESTAMP_EN
   ,
   output logic [15:0]              rd_ts
`endif
);

   localparam int CW = NUM_CH * DATA_W;
`ifdef PIPE_TRACE_TIMESTAMP_EN
   localparam int TS_W = 16;
`else
   localparam int TS_W = 0;
`endif
   localparam int MEM_W = CW + TS_W;

   localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
   localparam logic [AW:0] FILL_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [SW:0] NUM_CH_L = (SW+1)'(NUM_CH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PRE  = 2'b01,
      ST_POST = 2'b10,
      ST_READ = 2'b11
   } state_t;

   state_t            state_reg, state_next;
   logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [AW:0]       fill_reg, fill_next;
   logic [AW-1:0]     remain_reg, remain_next;
   logic [MEM_W-1:0]  mem [DEPTH];
   logic [MEM_W-1:0]  rd_q_reg;
   logic [MEM_W-1:0]  wr_word;
   logic              wr_en;
   logic              trig_ch_ok;
   logic              trig_hit;
   logic [DATA_W-1:0] trig_sel;
   logic [DATA_W-1:0] ch_word [NUM_CH];

   // Split the packed channel bus into one word per channel.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_word[gi] = ch_data[gi*DATA_W +: DATA_W];
   end

   // A channel index beyond NUM_CH must never fire, so it is screened before the compare.
   assign trig_ch_ok = ({1'b0, trig_ch} < NUM_CH_L);
   assign trig_sel   = trig_ch_ok ? ch_word[trig_ch] : '0;
   assign trig_hit   = sample_en && trig_ch_ok &&
                       (((trig_sel ^ trig_value) & trig_mask) == '0);

   // Samples are written only while capturing; abort suppresses the write.
   assign wr_en = sample_en && !abort &&
                  ((state_reg == ST_PRE) || (state_reg == ST_POST));

`ifdef PIPE_TRACE_TIMESTAMP_EN
   logic [15:0] ts_reg;

   // Free-running cycle stamp that is stored beside every sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ts_reg <= '0;
      else          ts_reg <= ts_reg + 16'd1;
   end

   assign wr_word = {ts_reg, ch_data};
`else
   assign wr_word = ch_data;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic; abort wins over every other event, including arm.
   always_comb begin
      state_next = state_reg;
      if (abort) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: if (arm) state_next = ST_PRE;
            ST_PRE:  if (trig_hit) state_next = (remain_reg == '0) ? ST_READ : ST_POST;
            ST_POST: if (sample_en && (remain_reg == PTR_ONE)) state_next = ST_READ;
            ST_READ: if (rd_ready && (fill_reg == FILL_ONE)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Pointer, fill and post-trigger countdown updates.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      fill_next   = fill_reg;
      remain_next = remain_reg;
      if (abort) begin
         fill_next = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (arm) begin
                  wr_ptr_next = '0;
                  fill_next   = '0;
                  remain_next = post_count;
               end
            end
            ST_PRE, ST_POST: begin
               if (wr_en) begin
                  wr_ptr_next = wr_ptr_reg + PTR_ONE;
                  fill_next   = (fill_reg == DEPTH_L) ? fill_reg : fill_reg + FILL_ONE;
                  if (state_reg == ST_POST) remain_next = remain_reg - PTR_ONE;
               end
            end
            ST_READ: begin
               // rd_valid is always high here, so rd_ready alone means accept.
               if (rd_ready) begin
                  rd_ptr_next = rd_ptr_reg + PTR_ONE;
                  fill_next   = fill_reg - FILL_ONE;
               end
            end
            default: ;
         endcase
         // On entry to READ, point at the oldest entry: wr_ptr once the ring has wrapped.
         if ((state_next == ST_READ) && (state_reg != ST_READ))
            rd_ptr_next = (fill_next == DEPTH_L) ? wr_ptr_next : '0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         fill_reg   <= '0;
         remain_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         fill_reg   <= fill_next;
         remain_reg <= remain_next;
      end
   end

   // Sample RAM with a registered write-first read. The read is addressed by the
   // next read pointer, so rd_q_reg already holds the entry rd_ptr will point at.
   // The bypass covers a single-entry capture whose only sample is written on the
   // same edge that enters READ.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= wr_word;
      rd_q_reg <= (wr_en && (wr_ptr_reg == rd_ptr_next)) ? wr_word : mem[rd_ptr_next];
   end

   // Outputs; read-side data is forced to zero whenever nothing is being offered.
   always_comb begin
      rd_valid = (state_reg == ST_READ);
      rd_last  = rd_valid && (fill_reg == FILL_ONE);
      rd_data  = rd_valid ? rd_q_reg[CW-1:0] : '0;
`ifdef PIPE_TRACE_TIMESTAMP_EN
      rd_ts    = rd_valid ? rd_q_reg[MEM_W-1 -: 16] : '0;
`endif
      state    = state_reg;
      fill     = fill_reg;
   end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb_pipe_trace_buffer: directed self-checking bench for pipe_trace_buffer.
module tb_pipe_trace_buffer;
   localparam int DATA_W = 16;
   localparam int NUM_CH = 4;
   localparam int DEPTH  = 16;
   localparam int AW     = 4;
   localparam int SW     = 2;

   logic                     clk = 1'b0;
   logic                     reset_n = 1'b0;
   logic                     sample_en = 1'b0;
   logic [NUM_CH*DATA_W-1:0] ch_data = '0;
   logic                     arm = 1'b0;
   logic                     abort = 1'b0;
   logic [SW-1:0]            trig_ch = '0;
   logic [DATA_W-1:0]        trig_value = '0;
   logic [DATA_W-1:0]        trig_mask = '0;
   logic [AW-1:0]            post_count = '0;
   logic                     rd_ready = 1'b0;
   logic                     rd_valid;
   logic [NUM_CH*DATA_W-1:0] rd_data;
   logic                     rd_last;
   logic [1:0]               state;
   logic [AW:0]              fill;
`ifdef PIPE_TRACE_TIMESTAMP_EN
   logic [15:0]              rd_ts;
`endif

   int checks = 0;
   int errors = 0;

   pipe_trace_buffer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .ch_data(ch_data),
      .arm(arm), .abort(abort), .trig_ch(trig_ch), .trig_value(trig_value),
      .trig_mask(trig_mask), .post_count(post_count), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .state(state), .fill(fill)
`ifdef PIPE_TRACE_TIMESTAMP_EN
      , .rd_ts(rd_ts)
`endif
   );

   always #5 clk = ~clk;

   // Distinct value on every channel so channel swaps show up.
   function automatic logic [63:0] pat(input logic [15:0] n);
      return {16'h3000 | n, 16'h2000 | n, 16'h1000 | n, n};
   endfunction

   // Arm with the given trigger setup; returns at the negedge after the arm edge.
   task automatic start(input logic [1:0] ch, input logic [15:0] val,
                        input logic [15:0] mask, input logic [3:0] pc);
      @(negedge clk);
      arm = 1'b1; trig_ch = ch; trig_value = val; trig_mask = mask; post_count = pc;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got %b exp 00", state); end
      checks++; if (fill !== 5'd0) begin errors++; $display("FAIL rst_fill got %0d exp 0", fill); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rd_valid); end
      checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", rd_last); end
      checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL rst_data got %h exp 0", rd_data); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic(input string tag);
      start(2'd0, 16'h0003, 16'hFFFF, 4'd2);
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL %s_pre got %b exp 01", tag, state); end
      for (int n = 1; n <= 5; n++) begin
         ch_data = pat(16'(n)); sample_en = 1'b1;
         @(negedge clk);
         if (n == 3) begin
            checks++; if (state !== 2'b10) begin errors++; $display("FAIL %s_post got %b exp 10", tag, state); end
         end
      end
      sample_en = 1'b0;
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL %s_read got %b exp 11", tag, state); end
      checks++; if (fill !== 5'd5) begin errors++; $display("FAIL %s_fill got %0d exp 5", tag, fill); end
      rd_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         checks++; if (rd_data !== pat(16'(i))) begin errors++; $display("FAIL %s_data%0d got %h exp %h", tag, i, rd_data, pat(16'(i))); end
         checks++; if (rd_last !== (i == 5)) begin errors++; $display("FAIL %s_last%0d got %b exp %b", tag, i, rd_last, (i == 5)); end
         $display("%s read %0d data %h last %b", tag, i, rd_data, rd_last);
         @(negedge clk);
      end
      rd_ready = 1'b0;
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL %s_idle got %b exp 00", tag, state); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL %s_novalid got %b exp 0", tag, rd_valid); end
      checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL %s_mask got %h exp 0", tag, rd_data); end
   endtask

   task automatic test_wrap();
      start(2'd0, 16'h001E, 16'hFFFF, 4'd4);
      for (int n = 1; n <= 40; n++) begin
         ch_data = pat(16'(n)); sample_en = 1'b1;
         @(negedge clk);
      end
      sample_en = 1'b0;
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL wrap_read got %b exp 11", state); end
      checks++; if (fill !== 5'd16) begin errors++; $display("FAIL wrap_fill got %0d exp 16", fill); end
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++; if (rd_data !== pat(16'(19 + i))) begin errors++; $display("FAIL wrap_data%0d got %h exp %h", i, rd_data, pat(16'(19 + i))); end
         checks++; if (rd_last !== (i == 15)) begin errors++; $display("FAIL wrap_last%0d got %b exp %b", i, rd_last, (i == 15)); end
         $display("wrap read %0d data %h last %b", i, rd_data, rd_last);
         @(negedge clk);
      end
      rd_ready = 1'b0;
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL wrap_idle got %b exp 00", state); end
   endtask

   task automatic test_mask();
      logic [63:0] a, b;
      a = {16'hC001, 16'hB001, 16'h1243, 16'hA001};
      b = {16'hC002, 16'hB002, 16'h1253, 16'hA002};
      start(2'd1, 16'h0050, 16'h00F0, 4'd0);
      ch_data = a; sample_en = 1'b1;
      @(negedge clk);
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL mask_nohit got %b exp 01", state); end
      ch_data = b;
      @(negedge clk);
      sample_en = 1'b0;
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL mask_hit got %b exp 11", state); end
      checks++; if (fill !== 5'd2) begin errors++; $display("FAIL mask_fill got %0d exp 2", fill); end
      rd_ready = 1'b1;
      checks++; if (rd_data !== a) begin errors++; $display("FAIL mask_data0 got %h exp %h", rd_data, a); end
      $display("mask read 0 data %h last %b", rd_data, rd_last);
      @(negedge clk);
      checks++; if (rd_data !== b) begin errors++; $display("FAIL mask_data1 got %h exp %h", rd_data, b); end
      checks++; if (rd_last !== 1'b1) begin errors++; $display("FAIL mask_last got %b exp 1", rd_last); end
      $display("mask read 1 data %h last %b", rd_data, rd_last);
      @(negedge clk);
      rd_ready = 1'b0;
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL mask_idle got %b exp 00", state); end
   endtask

   task automatic test_sample_en();
      logic [15:0] v [3];
      v = '{16'h0011, 16'h0022, 16'h0077};
      start(2'd0, 16'h0077, 16'hFFFF, 4'd0);
      ch_data = pat(16'h0011); sample_en = 1'b1; @(negedge clk);
      ch_data = pat(16'h0077); sample_en = 1'b0; @(negedge clk);
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL sen_state got %b exp 01", state); end
      checks++; if (fill !== 5'd1) begin errors++; $display("FAIL sen_fill got %0d exp 1", fill); end
      ch_data = pat(16'h0022); sample_en = 1'b1; @(negedge clk);
      ch_data = pat(16'h0077); @(negedge clk);
      sample_en = 1'b0;
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL sen_hit got %b exp 11", state); end
      checks++; if (fill !== 5'd3) begin errors++; $display("FAIL sen_fill3 got %0d exp 3", fill); end
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (rd_data !== pat(v[i])) begin errors++; $display("FAIL sen_data%0d got %h exp %h", i, rd_data, pat(v[i])); end
         $display("sen read %0d data %h last %b", i, rd_data, rd_last);
         @(negedge clk);
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_back_to_back_abort();
      start(2'd0, 16'h0044, 16'hFFFF, 4'd0);
      for (int n = 0; n < 4; n++) begin
         ch_data = pat(16'(16'h41 + n)); sample_en = 1'b1;
         @(negedge clk);
      end
      sample_en = 1'b0;
      checks++; if (fill !== 5'd4) begin errors++; $display("FAIL hs_fill got %0d exp 4", fill); end
      rd_ready = 1'b1;
      checks++; if (rd_data !== pat(16'h41)) begin errors++; $display("FAIL hs_d0 got %h exp %h", rd_data, pat(16'h41)); end
      @(negedge clk); rd_ready = 1'b0;
      checks++; if (rd_data !== pat(16'h42)) begin errors++; $display("FAIL hs_d1 got %h exp %h", rd_data, pat(16'h42)); end
      @(negedge clk); rd_ready = 1'b1;
      checks++; if (rd_data !== pat(16'h42)) begin errors++; $display("FAIL hs_hold got %h exp %h", rd_data, pat(16'h42)); end
      @(negedge clk); rd_ready = 1'b0;
      checks++; if (rd_data !== pat(16'h43)) begin errors++; $display("FAIL hs_d2 got %h exp %h", rd_data, pat(16'h43)); end
      @(negedge clk);
      checks++; if (fill !== 5'd2) begin errors++; $display("FAIL hs_fill2 got %0d exp 2", fill); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", rd_valid); end
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL abort_state got %b exp 00", state); end
      checks++; if (fill !== 5'd0) begin errors++; $display("FAIL abort_fill got %0d exp 0", fill); end
      checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL abort_data got %h exp 0", rd_data); end
      arm = 1'b1; abort = 1'b1;
      @(negedge clk);
      arm = 1'b0; abort = 1'b0;
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL armabort got %b exp 00", state); end
   endtask

   task automatic test_async_reset();
      start(2'd0, 16'h0001, 16'hFFFF, 4'd5);
      ch_data = pat(16'd1); sample_en = 1'b1; @(negedge clk);
      ch_data = pat(16'd2); @(negedge clk);
      sample_en = 1'b0;
      checks++; if (state !== 2'b10) begin errors++; $display("FAIL ar_post got %b exp 10", state); end
      checks++; if (fill !== 5'd2) begin errors++; $display("FAIL ar_fill got %0d exp 2", fill); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL ar_state got %b exp 00", state); end
      checks++; if (fill !== 5'd0) begin errors++; $display("FAIL ar_fill0 got %0d exp 0", fill); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", rd_valid); end
      @(negedge clk);
      reset_n = 1'b1;
      test_basic("ar_t1");
   endtask

   initial begin
      test_reset();
      test_basic("t1");
      test_wrap();
      test_mask();
      test_sample_en();
      test_back_to_back_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
